difi_ctrlport_regs: RTL and testbench

- CtrlPort slave register bank for the DIFI block's user logic.
- Terminates the m_ctrlport_* master interface that the DIFI NoC shell drives.
- Holds DIFI framing configuration: enable, stream ID, OUI, class codes, packet size.
- Exposes saturating packet and error counters plus a sticky error flag for host readback.

---
 rtl/difi_ctrlport_regs_pkg.sv | 33 +++
 rtl/difi_sat_counter.sv | 36 +++
 rtl/difi_ctrlport_regs.sv | 184 ++++++++++++++++++
 tb/tb_difi_ctrlport_regs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/difi_ctrlport_regs_pkg.sv
// Shared register map for the DIFI CtrlPort register bank: byte offsets,
// compatibility word, bit positions and the packet-size sanitiser.
package difi_ctrlport_regs_pkg;

  localparam logic [7:0] REG_COMPAT    = 8'h00;
  localparam logic [7:0] REG_CTRL      = 8'h04;
  localparam logic [7:0] REG_STREAM_ID = 8'h08;
  localparam logic [7:0] REG_OUI       = 8'h0C;
  localparam logic [7:0] REG_CLASS     = 8'h10;
  localparam logic [7:0] REG_PKT_SIZE  = 8'h14;
  localparam logic [7:0] REG_PKT_COUNT = 8'h18;
  localparam logic [7:0] REG_ERR_COUNT = 8'h1C;
  localparam logic [7:0] REG_STATUS    = 8'h20;

  localparam logic [31:0] COMPAT_VALUE = 32'h0001_0000;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_CLEAR_BIT    = 1;
  localparam int STATUS_STICKY_BIT = 0;
  localparam int STATUS_ENABLE_BIT = 1;

  // A packet of zero samples is meaningless to the framer, so 0 becomes 1.
  function automatic logic [15:0] sanitize_pkt_size(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'd0) begin
      result = 16'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/difi_sat_counter.sv
// 32-bit saturating event counter; clear has priority over increment.
module difi_sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] cnt
);

  logic [31:0] cnt_d;
  logic [31:0] cnt_q;

  // Next count: clear first, otherwise step unless already at full scale.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 32'd0;
    end else if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/difi_ctrlport_regs.sv
// CtrlPort slave register bank holding DIFI framing configuration and
// exposing packet/error counters and a sticky error flag.
module difi_ctrlport_regs
  import difi_ctrlport_regs_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR    = 20'h0,
  parameter int          WIN_AW       = 6,
  parameter logic [15:0] DEF_PKT_SIZE = 16'd364
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst,
  input  logic        s_ctrlport_req_wr,
  input  logic        s_ctrlport_req_rd,
  input  logic [19:0] s_ctrlport_req_addr,
  input  logic [31:0] s_ctrlport_req_data,
  output logic        s_ctrlport_resp_ack,
  output logic [31:0] s_ctrlport_resp_data,
  output logic        cfg_enable,
  output logic [31:0] cfg_stream_id,
  output logic [23:0] cfg_oui,
  output logic [15:0] cfg_info_class,
  output logic [15:0] cfg_pkt_class,
  output logic [15:0] cfg_pkt_size,
  output logic        clear_pulse,
  input  logic        pkt_done_stb,
  input  logic        err_stb
);

  localparam logic [20:0] WIN_SIZE = 21'd1 << WIN_AW;

  logic [20:0] win_off_s;
  logic        in_win_s;
  logic [7:0]  reg_off_s;
  logic        wr_s;
  logic        clear_s;
  logic        w1c_s;
  logic [31:0] rdata_s;
  logic [31:0] pkt_cnt_s;
  logic [31:0] err_cnt_s;

  logic        ack_d,        ack_q;
  logic [31:0] resp_data_d,  resp_data_q;
  logic        enable_d,     enable_q;
  logic [31:0] stream_id_d,  stream_id_q;
  logic [23:0] oui_d,        oui_q;
  logic [15:0] info_class_d, info_class_q;
  logic [15:0] pkt_class_d,  pkt_class_q;
  logic [15:0] pkt_size_d,   pkt_size_q;
  logic        clear_pulse_d, clear_pulse_q;
  logic        err_sticky_d, err_sticky_q;

  // Window hit detection; address bits [1:0] are dropped from the offset.
  always_comb begin
    win_off_s = {1'b0, s_ctrlport_req_addr} - {1'b0, BASE_ADDR};
    in_win_s  = ({1'b0, s_ctrlport_req_addr} >= {1'b0, BASE_ADDR}) &&
                (win_off_s < WIN_SIZE);
    reg_off_s = {win_off_s[7:2], 2'b00};
    wr_s      = s_ctrlport_req_wr & in_win_s;
  end

  // Read mux over the pre-update register contents.
  always_comb begin
    rdata_s = 32'd0;
    case (reg_off_s)
      REG_COMPAT:    rdata_s = COMPAT_VALUE;
      REG_CTRL:      rdata_s = {31'd0, enable_q};
      REG_STREAM_ID: rdata_s = stream_id_q;
      REG_OUI:       rdata_s = {8'd0, oui_q};
      REG_CLASS:     rdata_s = {pkt_class_q, info_class_q};
      REG_PKT_SIZE:  rdata_s = {16'd0, pkt_size_q};
      REG_PKT_COUNT: rdata_s = pkt_cnt_s;
      REG_ERR_COUNT: rdata_s = err_cnt_s;
      REG_STATUS:    rdata_s = {30'd0, enable_q, err_sticky_q};
      default:       rdata_s = 32'd0;
    endcase
  end

  // Write decode, response generation and sticky-flag update.
  always_comb begin
    enable_d     = enable_q;
    stream_id_d  = stream_id_q;
    oui_d        = oui_q;
    info_class_d = info_class_q;
    pkt_class_d  = pkt_class_q;
    pkt_size_d   = pkt_size_q;
    clear_s      = 1'b0;
    w1c_s        = 1'b0;
    if (wr_s) begin
      case (reg_off_s)
        REG_CTRL: begin
          enable_d = s_ctrlport_req_data[CTRL_ENABLE_BIT];
          clear_s  = s_ctrlport_req_data[CTRL_CLEAR_BIT];
        end
        REG_STREAM_ID: stream_id_d = s_ctrlport_req_data;
        REG_OUI:       oui_d = s_ctrlport_req_data[23:0];
        REG_CLASS: begin
          info_class_d = s_ctrlport_req_data[15:0];
          pkt_class_d  = s_ctrlport_req_data[31:16];
        end
        REG_PKT_SIZE:  pkt_size_d = sanitize_pkt_size(s_ctrlport_req_data[15:0]);
        REG_STATUS:    w1c_s = s_ctrlport_req_data[STATUS_STICKY_BIT];
        default: begin
          clear_s = 1'b0;
        end
      endcase
    end else begin
      clear_s = 1'b0;
    end

    clear_pulse_d = clear_s;

    // A new error outranks a software clear-by-write arriving alongside it.
    if (clear_s) begin
      err_sticky_d = 1'b0;
    end else if (err_stb) begin
      err_sticky_d = 1'b1;
    end else if (w1c_s) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end

    ack_d = (s_ctrlport_req_wr | s_ctrlport_req_rd) & in_win_s;
    if (ack_d) begin
      resp_data_d = rdata_s;
    end else begin
      resp_data_d = 32'd0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      ack_q         <= 1'b0;
      resp_data_q   <= 32'd0;
      enable_q      <= 1'b0;
      stream_id_q   <= 32'd0;
      oui_q         <= 24'd0;
      info_class_q  <= 16'd0;
      pkt_class_q   <= 16'd0;
      pkt_size_q    <= sanitize_pkt_size(DEF_PKT_SIZE);
      clear_pulse_q <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      ack_q         <= ack_d;
      resp_data_q   <= resp_data_d;
      enable_q      <= enable_d;
      stream_id_q   <= stream_id_d;
      oui_q         <= oui_d;
      info_class_q  <= info_class_d;
      pkt_class_q   <= pkt_class_d;
      pkt_size_q    <= pkt_size_d;
      clear_pulse_q <= clear_pulse_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  difi_sat_counter u_pkt_cnt (
    .clk (ctrlport_clk),
    .rst (ctrlport_rst),
    .inc (pkt_done_stb),
    .clr (clear_s),
    .cnt (pkt_cnt_s)
  );

  difi_sat_counter u_err_cnt (
    .clk (ctrlport_clk),
    .rst (ctrlport_rst),
    .inc (err_stb),
    .clr (clear_s),
    .cnt (err_cnt_s)
  );

  assign s_ctrlport_resp_ack  = ack_q;
  assign s_ctrlport_resp_data = resp_data_q;
  assign cfg_enable           = enable_q;
  assign cfg_stream_id        = stream_id_q;
  assign cfg_oui              = oui_q;
  assign cfg_info_class       = info_class_q;
  assign cfg_pkt_class        = pkt_class_q;
  assign cfg_pkt_size         = pkt_size_q;
  assign clear_pulse          = clear_pulse_q;

endmodule

// File: tb/tb_difi_ctrlport_regs.sv
// Self-checking bench for difi_ctrlport_regs: directed steps followed by a
// randomized run, all compared against a register-level reference model.
module tb_difi_ctrlport_regs;
  import difi_ctrlport_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_wr;
  logic        req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        cfg_enable;
  logic [31:0] cfg_stream_id;
  logic [23:0] cfg_oui;
  logic [15:0] cfg_info_class;
  logic [15:0] cfg_pkt_class;
  logic [15:0] cfg_pkt_size;
  logic        clear_pulse;
  logic        pkt_stb;
  logic        err_stb;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state (what the host should observe).
  logic        m_enable;
  logic [31:0] m_sid;
  logic [23:0] m_oui;
  logic [15:0] m_icls;
  logic [15:0] m_pcls;
  logic [15:0] m_psize;
  logic [31:0] m_pkt;
  logic [31:0] m_err;
  logic        m_sticky;
  logic        m_clr;

  always #5 clk = ~clk;

  difi_ctrlport_regs dut (
    .ctrlport_clk         (clk),
    .ctrlport_rst         (rst),
    .s_ctrlport_req_wr    (req_wr),
    .s_ctrlport_req_rd    (req_rd),
    .s_ctrlport_req_addr  (req_addr),
    .s_ctrlport_req_data  (req_data),
    .s_ctrlport_resp_ack  (resp_ack),
    .s_ctrlport_resp_data (resp_data),
    .cfg_enable           (cfg_enable),
    .cfg_stream_id        (cfg_stream_id),
    .cfg_oui              (cfg_oui),
    .cfg_info_class       (cfg_info_class),
    .cfg_pkt_class        (cfg_pkt_class),
    .cfg_pkt_size         (cfg_pkt_size),
    .clear_pulse          (clear_pulse),
    .pkt_done_stb         (pkt_stb),
    .err_stb              (err_stb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_enable = 1'b0; m_sid = 32'd0; m_oui = 24'd0; m_icls = 16'd0; m_pcls = 16'd0;
    m_psize = 16'd364; m_pkt = 32'd0; m_err = 32'd0; m_sticky = 1'b0; m_clr = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0:       return 32'h0001_0000;
      4:       return {31'd0, m_enable};
      8:       return m_sid;
      12:      return {8'd0, m_oui};
      16:      return {m_pcls, m_icls};
      20:      return {16'd0, m_psize};
      24:      return m_pkt;
      28:      return m_err;
      32:      return {30'd0, m_enable, m_sticky};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] sat_step(input logic [31:0] v, input logic clr, input logic inc);
    if (clr) return 32'd0;
    if (inc && v != 32'hFFFF_FFFF) return v + 32'd1;
    return v;
  endfunction

  // One bus cycle: drive at negedge, predict, check 1 ns after the posedge.
  task automatic cycle(input logic r, input logic wr, input logic rd, input logic [19:0] addr,
                       input logic [31:0] data, input logic pkt, input logic err);
    logic        hit;
    int          off;
    logic        exp_ack;
    logic [31:0] exp_rd;
    logic        clr;
    logic        w1c;
    @(negedge clk);
    rst = r; req_wr = wr; req_rd = rd; req_addr = addr; req_data = data;
    pkt_stb = pkt; err_stb = err;
    hit     = (int'(addr) < 64);
    off     = int'(addr) & 32'h3C;
    exp_rd  = model_read(off);
    exp_ack = !r && (wr || rd) && hit;
    clr     = !r && wr && hit && off == 4 && data[1];
    w1c     = !r && wr && hit && off == 32 && data[0];
    if (r) begin
      model_reset();
    end else begin
      if (wr && hit) begin
        case (off)
          4:  m_enable = data[0];
          8:  m_sid = data;
          12: m_oui = data[23:0];
          16: begin m_icls = data[15:0]; m_pcls = data[31:16]; end
          20: m_psize = (data[15:0] == 16'd0) ? 16'd1 : data[15:0];
          default: ;
        endcase
      end
      m_pkt = sat_step(m_pkt, clr, pkt);
      m_err = sat_step(m_err, clr, err);
      if (clr) m_sticky = 1'b0;
      else if (err) m_sticky = 1'b1;
      else if (w1c) m_sticky = 1'b0;
      m_clr = clr;
    end
    @(posedge clk);
    #1;
    chk("ack", resp_ack, exp_ack);
    if (exp_ack && rd) chk("rdata", resp_data, exp_rd);
    else if (!exp_ack) chk("rdata_idle", resp_data, 32'd0);
    chk("clear_pulse", clear_pulse, m_clr);
    chk("cfg_enable", cfg_enable, m_enable);
    chk("cfg_stream_id", cfg_stream_id, m_sid);
    chk("cfg_oui", cfg_oui, m_oui);
    chk("cfg_info_class", cfg_info_class, m_icls);
    chk("cfg_pkt_class", cfg_pkt_class, m_pcls);
    chk("cfg_pkt_size", cfg_pkt_size, m_psize);
  endtask

  task automatic rd_reg(input logic [19:0] addr);
    cycle(1'b0, 1'b0, 1'b1, addr, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wr_reg(input logic [19:0] addr, input logic [31:0] data);
    cycle(1'b0, 1'b1, 1'b0, addr, data, 1'b0, 1'b0);
  endtask

  initial begin
    logic [19:0] a;
    logic [31:0] d;
    rst = 1'b1; req_wr = 1'b0; req_rd = 1'b0; req_addr = 20'd0; req_data = 32'd0;
    pkt_stb = 1'b0; err_stb = 1'b0;
    model_reset();

    // Reset and reset-value readback.
    cycle(1'b1, 1'b0, 1'b0, 20'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 20'd0, 32'd0, 1'b0, 1'b0);
    rd_reg(20'h00);
    chk("compat_const", resp_data, 32'h0001_0000);
    rd_reg(20'h14);
    chk("pkt_size_rst", resp_data, 32'd364);
    rd_reg(20'h18);

    // Configuration writes and readback.
    wr_reg(20'h08, 32'hDEAD_BEEF);
    chk("sid_const", cfg_stream_id, 32'hDEAD_BEEF);
    wr_reg(20'h0C, 32'hFF12_3456);
    chk("oui_const", cfg_oui, 24'h12_3456);
    wr_reg(20'h10, 32'h0002_0001);
    rd_reg(20'h08);
    rd_reg(20'h0C);
    chk("oui_upper_zero", resp_data, 32'h0012_3456);
    rd_reg(20'h13);

    // PKT_SIZE zero, unmapped and out-of-window accesses.
    wr_reg(20'h14, 32'd0);
    chk("pkt_size_min", cfg_pkt_size, 16'd1);
    rd_reg(20'h14);
    rd_reg(20'h3C);
    rd_reg(20'h40);
    chk("outside_no_ack", resp_ack, 1'b0);
    wr_reg(20'h44, 32'h1234_5678);

    // Packet counting and clear coinciding with a strobe.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 20'd0, 32'd0, 1'b1, 1'b0);
    rd_reg(20'h18);
    chk("pkt_five", resp_data, 32'd5);
    cycle(1'b0, 1'b1, 1'b0, 20'h04, 32'd2, 1'b1, 1'b0);
    chk("clear_hi", clear_pulse, 1'b1);
    rd_reg(20'h18);
    chk("pkt_cleared", resp_data, 32'd0);

    // Saturation from a preloaded count.
    @(negedge clk);
    force dut.u_pkt_cnt.cnt_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.u_pkt_cnt.cnt_d;
    m_pkt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 20'd0, 32'd0, 1'b1, 1'b0);
    rd_reg(20'h18);
    chk("pkt_saturated", resp_data, 32'hFFFF_FFFF);

    // Error flag and counter, W1C racing an error.
    cycle(1'b0, 1'b0, 1'b0, 20'd0, 32'd0, 1'b0, 1'b1);
    rd_reg(20'h20);
    rd_reg(20'h1C);
    chk("err_one", resp_data, 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 20'h20, 32'd1, 1'b0, 1'b1);
    rd_reg(20'h20);
    chk("sticky_held", resp_data[0], 1'b1);
    wr_reg(20'h20, 32'd1);
    rd_reg(20'h20);
    chk("sticky_cleared", resp_data[0], 1'b0);

    // Simultaneous write and read returns pre-write contents.
    cycle(1'b0, 1'b1, 1'b1, 20'h04, 32'd1, 1'b0, 1'b0);
    chk("wr_rd_old", resp_data, 32'd0);
    rd_reg(20'h04);
    rd_reg(20'h20);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      a = 20'($urandom_range(0, 71));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[15:0] = 16'd0;
      if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    // Reset mid-read drops the ack and restores defaults.
    wr_reg(20'h08, 32'h0BAD_F00D);
    wr_reg(20'h04, 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 20'h08, 32'd0, 1'b1, 1'b1);
    chk("rst_no_ack", resp_ack, 1'b0);
    rd_reg(20'h08);
    rd_reg(20'h14);
    rd_reg(20'h20);
    rd_reg(20'h18);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
